mc_ctrl_unit: RTL and testbench

- Parametrised multicycle MIPS-subset control FSM; successor to the current fixed-latency control unit.
- Drives the shared multicycle datapath: PC, IR, register file, ALU, unified memory.
- New versus the current unit: variable-latency memory handshake with wait states, BNE, SUB/AND/OR/SLT R-types, illegal-opcode trap to a vector, and a retired-instruction counter.

---
 rtl/mc_pkg.sv | 80 ++++++++
 rtl/mc_alu_dec.sv | 56 +++++
 rtl/mc_ctrl_unit.sv | 202 ++++++++++++++++++++
 tb/tb_mc_ctrl_unit.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle control unit: states, opcodes, ALU codes, mux selects.
package mc_pkg;

  localparam int unsigned ALU_W   = 3;
  localparam int unsigned STATE_W = 4;

  typedef enum logic [STATE_W-1:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    EXEC_R   = 4'd2,
    WB_R     = 4'd3,
    EXEC_I   = 4'd4,
    WB_I     = 4'd5,
    MEM_ADDR = 4'd6,
    MEM_RD   = 4'd7,
    WB_MEM   = 4'd8,
    MEM_WR   = 4'd9,
    BRANCH   = 4'd10,
    JUMP     = 4'd11,
    JAL      = 4'd12,
    JR       = 4'd13,
    TRAP     = 4'd14
  } state_e;

  // Opcodes (IR[31:26])
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_MUL   = 6'h1C;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type function codes (IR[5:0])
  localparam logic [5:0] F_JR  = 6'h08;
  localparam logic [5:0] F_ADD = 6'h20;
  localparam logic [5:0] F_SUB = 6'h22;
  localparam logic [5:0] F_AND = 6'h24;
  localparam logic [5:0] F_OR  = 6'h25;
  localparam logic [5:0] F_SLT = 6'h2A;

  // ALU operation codes
  localparam logic [ALU_W-1:0] ALU_ADD   = 3'b001;
  localparam logic [ALU_W-1:0] ALU_AND   = 3'b010;
  localparam logic [ALU_W-1:0] ALU_OR    = 3'b011;
  localparam logic [ALU_W-1:0] ALU_SUB   = 3'b100;
  localparam logic [ALU_W-1:0] ALU_SLT   = 3'b101;
  localparam logic [ALU_W-1:0] ALU_MUL   = 3'b110;
  localparam logic [ALU_W-1:0] ALU_PASSA = 3'b111;

  // PC source select
  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;
  localparam logic [1:0] PC_TRAP   = 2'b11;

  // Register destination select
  localparam logic [1:0] RD_RT = 2'b00;
  localparam logic [1:0] RD_RD = 2'b01;
  localparam logic [1:0] RD_RA = 2'b10;

  // Immediate extension mode
  localparam logic [1:0] EXT_SIGN = 2'b00;
  localparam logic [1:0] EXT_ZERO = 2'b01;
  localparam logic [1:0] EXT_LUI  = 2'b10;

  // ALU B operand select
  localparam logic [1:0] SRCB_RT     = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

endpackage

// File: rtl/mc_alu_dec.sv
// Combinational instruction decoder: op/funct -> ALU operation, immediate extension, legality.
module mc_alu_dec
  import mc_pkg::*;
#(
  parameter int unsigned HAS_MUL = 1
) (
  input  logic [5:0]       op,
  input  logic [5:0]       funct,
  output logic [ALU_W-1:0] alu_ctrl,
  output logic [1:0]       ext_mode,
  output logic             legal
);

  // Decode the instruction fields held in IR
  always_comb begin
    alu_ctrl = ALU_ADD;
    ext_mode = EXT_SIGN;
    legal    = 1'b1;
    case (op)
      OP_RTYPE: begin
        case (funct)
          F_ADD:   alu_ctrl = ALU_ADD;
          F_SUB:   alu_ctrl = ALU_SUB;
          F_AND:   alu_ctrl = ALU_AND;
          F_OR:    alu_ctrl = ALU_OR;
          F_SLT:   alu_ctrl = ALU_SLT;
          F_JR:    alu_ctrl = ALU_PASSA;
          default: legal    = 1'b0;
        endcase
      end
      OP_MUL: begin
        alu_ctrl = ALU_MUL;
        legal    = (HAS_MUL != 0);
      end
      OP_ADDI, OP_ADDIU: alu_ctrl = ALU_ADD;
      OP_SLTI:           alu_ctrl = ALU_SLT;
      OP_ANDI: begin
        alu_ctrl = ALU_AND;
        ext_mode = EXT_ZERO;
      end
      OP_ORI: begin
        alu_ctrl = ALU_OR;
        ext_mode = EXT_ZERO;
      end
      // LUI computes $0 | (imm << 16)
      OP_LUI: begin
        alu_ctrl = ALU_OR;
        ext_mode = EXT_LUI;
      end
      OP_BEQ, OP_BNE:            alu_ctrl = ALU_SUB;
      OP_LW, OP_SW, OP_J, OP_JAL: alu_ctrl = ALU_ADD;
      default:                   legal    = 1'b0;
    endcase
  end

endmodule

// File: rtl/mc_ctrl_unit.sv
// Multicycle MIPS-subset control FSM with memory wait states, trap vector and retired counter.
module mc_ctrl_unit
  import mc_pkg::*;
#(
  parameter int unsigned ALU_CTRL_W = 3,
  parameter int unsigned HAS_MUL    = 1,
  parameter int unsigned CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [5:0]            op,
  input  logic [5:0]            funct,
  input  logic                  zero,
  input  logic                  mem_ready,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic                  iord,
  output logic                  ir_write,
  output logic                  pc_write,
  output logic [1:0]            pc_src,
  output logic                  reg_write,
  output logic [1:0]            reg_dst,
  output logic                  mem_to_reg,
  output logic                  alu_src_a,
  output logic [1:0]            alu_src_b,
  output logic [1:0]            ext_mode,
  output logic [ALU_CTRL_W-1:0] alu_ctrl,
  output logic                  illegal_instr,
  output logic [CNT_W-1:0]      retired,
  output logic [3:0]            state_dbg
);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  retired_q, retired_d;
  logic              retire;
  logic [ALU_W-1:0]  dec_alu;
  logic [ALU_W-1:0]  alu_code;
  logic [1:0]        dec_ext;
  logic              dec_legal;

  mc_alu_dec #(.HAS_MUL(HAS_MUL)) u_dec (
    .op       (op),
    .funct    (funct),
    .alu_ctrl (dec_alu),
    .ext_mode (dec_ext),
    .legal    (dec_legal)
  );

  // State and retired-count registers; reset abandons any in-flight instruction
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= FETCH;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      retired_q <= retired_d;
    end
  end

  // Next-state sequencing and retirement detection
  always_comb begin
    state_d = state_q;
    retire  = 1'b0;
    case (state_q)
      FETCH:  if (mem_ready) state_d = DECODE;
      DECODE: begin
        if (!dec_legal) begin
          state_d = TRAP;
        end else begin
          case (op)
            OP_RTYPE: state_d = (funct == F_JR) ? JR : EXEC_R;
            OP_MUL:   state_d = EXEC_R;
            OP_ADDI, OP_ADDIU, OP_SLTI,
            OP_ANDI, OP_ORI, OP_LUI: state_d = EXEC_I;
            OP_LW, OP_SW:   state_d = MEM_ADDR;
            OP_BEQ, OP_BNE: state_d = BRANCH;
            OP_J:           state_d = JUMP;
            OP_JAL:         state_d = JAL;
            default:        state_d = TRAP;
          endcase
        end
      end
      EXEC_R:   state_d = WB_R;
      EXEC_I:   state_d = WB_I;
      MEM_ADDR: state_d = (op == OP_SW) ? MEM_WR : MEM_RD;
      MEM_RD:   if (mem_ready) state_d = WB_MEM;
      MEM_WR: begin
        if (mem_ready) begin
          state_d = FETCH;
          retire  = 1'b1;
        end
      end
      WB_R, WB_I, WB_MEM, BRANCH, JUMP, JAL, JR: begin
        state_d = FETCH;
        retire  = 1'b1;
      end
      TRAP:    state_d = FETCH;
      default: state_d = FETCH;
    endcase
    retired_d = retire ? (retired_q + CNT_W'(1)) : retired_q;
  end

  // Datapath control decode from the current state
  always_comb begin
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    iord          = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_src        = PC_ALU;
    reg_write     = 1'b0;
    reg_dst       = RD_RT;
    mem_to_reg    = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = SRCB_RT;
    ext_mode      = EXT_SIGN;
    alu_code      = ALU_ADD;
    illegal_instr = 1'b0;
    case (state_q)
      FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = SRCB_FOUR;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      DECODE: alu_src_b = SRCB_IMM_SH;
      EXEC_R: begin
        alu_src_a = 1'b1;
        alu_code  = dec_alu;
      end
      WB_R: begin
        alu_src_a = 1'b1;
        alu_code  = dec_alu;
        reg_write = 1'b1;
        reg_dst   = RD_RD;
      end
      EXEC_I: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        alu_code  = dec_alu;
        ext_mode  = dec_ext;
      end
      WB_I: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        alu_code  = dec_alu;
        ext_mode  = dec_ext;
        reg_write = 1'b1;
      end
      MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
      end
      MEM_RD: begin
        iord     = 1'b1;
        mem_read = 1'b1;
      end
      WB_MEM: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      MEM_WR: begin
        iord      = 1'b1;
        mem_write = 1'b1;
      end
      BRANCH: begin
        alu_src_a = 1'b1;
        alu_code  = ALU_SUB;
        pc_src    = PC_ALUOUT;
        pc_write  = (op == OP_BNE) ? ~zero : zero;
      end
      JUMP: begin
        pc_src   = PC_JUMP;
        pc_write = 1'b1;
      end
      // Link and jump in one cycle: PC still holds PC+4 for the $31 write
      JAL: begin
        alu_code  = ALU_PASSA;
        reg_dst   = RD_RA;
        reg_write = 1'b1;
        pc_src    = PC_JUMP;
        pc_write  = 1'b1;
      end
      JR: begin
        alu_src_a = 1'b1;
        alu_code  = ALU_PASSA;
        pc_write  = 1'b1;
      end
      TRAP: begin
        pc_src        = PC_TRAP;
        pc_write      = 1'b1;
        illegal_instr = 1'b1;
      end
      default: ;
    endcase
  end

  assign alu_ctrl  = ALU_CTRL_W'(alu_code);
  assign retired   = retired_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_mc_ctrl_unit.sv
// Scoreboard bench for mc_ctrl_unit: per-cycle expected control words are queued by the
// driver and compared by an independent monitor on the falling edge.
module tb_mc_ctrl_unit;

  localparam int unsigned CW = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [5:0]    op = 6'h00;
  logic [5:0]    funct = 6'h00;
  logic          zero = 1'b0;
  logic          mem_ready = 1'b0;
  logic          mem_read, mem_write, iord, ir_write, pc_write;
  logic [1:0]    pc_src, reg_dst, alu_src_b, ext_mode;
  logic          reg_write, mem_to_reg, alu_src_a, illegal_instr;
  logic [2:0]    alu_ctrl;
  logic [CW-1:0] retired;
  logic [3:0]    state_dbg;

  mc_ctrl_unit #(.ALU_CTRL_W(3), .HAS_MUL(0), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
    .mem_read(mem_read), .mem_write(mem_write), .iord(iord), .ir_write(ir_write),
    .pc_write(pc_write), .pc_src(pc_src), .reg_write(reg_write), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .ext_mode(ext_mode), .alu_ctrl(alu_ctrl), .illegal_instr(illegal_instr),
    .retired(retired), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]    st;
    logic          mr, mw, io, irw, pcw;
    logic [1:0]    pcs;
    logic          rw;
    logic [1:0]    rd;
    logic          m2r, a;
    logic [1:0]    b, ext;
    logic [2:0]    alu;
    logic          ill;
    logic [CW-1:0] ret;
  } exp_t;

  exp_t       exp_q[$];
  string      tag_q[$];
  int         checks = 0;
  int         failures = 0;
  string      cur_tag = "";
  logic [5:0] cur_op = 6'h00;
  logic [5:0] cur_funct = 6'h00;

  function automatic exp_t mk(input int st, mr, mw, io, irw, pcw, pcs, rw, rd, m2r,
                              a, b, ext, alu, ill, ret);
    exp_t e;
    e.st = 4'(st);   e.mr = 1'(mr);   e.mw = 1'(mw);   e.io = 1'(io);
    e.irw = 1'(irw); e.pcw = 1'(pcw); e.pcs = 2'(pcs); e.rw = 1'(rw);
    e.rd = 2'(rd);   e.m2r = 1'(m2r); e.a = 1'(a);     e.b = 2'(b);
    e.ext = 2'(ext); e.alu = 3'(alu); e.ill = 1'(ill); e.ret = CW'(ret);
    return e;
  endfunction

  // FETCH word (ir/pc load follow mem_ready) and DECODE word
  function automatic exp_t fe(input int rdy, input int r);
    return mk(0, 1, 0, 0, rdy, rdy, 0, 0, 0, 0, 0, 1, 0, 1, 0, r);
  endfunction
  function automatic exp_t de(input int r);
    return mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 0, 1, 0, r);
  endfunction

  function automatic exp_t got_now();
    exp_t g;
    g.st = state_dbg;  g.mr = mem_read;    g.mw = mem_write;  g.io = iord;
    g.irw = ir_write;  g.pcw = pc_write;   g.pcs = pc_src;    g.rw = reg_write;
    g.rd = reg_dst;    g.m2r = mem_to_reg; g.a = alu_src_a;   g.b = alu_src_b;
    g.ext = ext_mode;  g.alu = alu_ctrl;   g.ill = illegal_instr; g.ret = retired;
    return g;
  endfunction

  task automatic chk(input string name, input exp_t g, input exp_t e);
    checks++;
    if (g !== e) begin
      failures++;
      $display("FAIL %s: got st=%0d word=%h ret=%0d, expected st=%0d word=%h ret=%0d",
               name, g.st, g, g.ret, e.st, e, e.ret);
    end
  endtask

  task automatic instr(input string name, input logic [5:0] o, input logic [5:0] f);
    cur_tag = name; cur_op = o; cur_funct = f;
  endtask

  // One clock cycle: apply inputs just after the edge, queue the expected control word
  task automatic cyc(input logic rdy, input logic z, input exp_t e);
    @(posedge clk);
    #1;
    op = cur_op; funct = cur_funct; mem_ready = rdy; zero = z;
    exp_q.push_back(e);
    tag_q.push_back(cur_tag);
  endtask

  // Monitor: every cycle with a pending expectation is compared at the falling edge
  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        exp_t  e;
        string t;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        chk(t, got_now(), e);
      end
    end
  end

  initial begin
    #12;
    chk("reset_state", got_now(), fe(0, 0));
    @(negedge clk);
    rst = 1'b0;

    // ADD with one fetch wait cycle
    instr("add", 6'h00, 6'h20);
    cyc(0, 0, fe(0, 0));
    cyc(1, 0, fe(1, 0));
    cyc(1, 0, de(0));
    cyc(1, 0, mk(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0));
    cyc(1, 0, mk(3, 0, 0, 0, 0, 0, 0, 1, 1, 0, 1, 0, 0, 1, 0, 0));

    // ORI: zero-extended OR
    instr("ori", 6'h0D, 6'h00);
    cyc(1, 0, fe(1, 1));
    cyc(1, 0, de(1));
    cyc(1, 0, mk(4, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 1, 3, 0, 1));
    cyc(1, 0, mk(5, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 2, 1, 3, 0, 1));

    // SLT R-type
    instr("slt", 6'h00, 6'h2A);
    cyc(1, 0, fe(1, 2));
    cyc(1, 0, de(2));
    cyc(1, 0, mk(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 5, 0, 2));
    cyc(1, 0, mk(3, 0, 0, 0, 0, 0, 0, 1, 1, 0, 1, 0, 0, 5, 0, 2));

    // LW with three memory wait cycles: 8 cycles total
    instr("lw", 6'h23, 6'h00);
    cyc(1, 0, fe(1, 3));
    cyc(1, 0, de(3));
    cyc(1, 0, mk(6, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 0, 1, 0, 3));
    cyc(0, 0, mk(7, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 3));
    cyc(0, 0, mk(7, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 3));
    cyc(0, 0, mk(7, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 3));
    cyc(1, 0, mk(7, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 3));
    cyc(1, 0, mk(8, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 1, 0, 3));

    // BNE with zero=1 (not taken) then zero=0 (taken)
    instr("bne_nt", 6'h05, 6'h00);
    cyc(1, 0, fe(1, 4));
    cyc(1, 0, de(4));
    cyc(1, 1, mk(10, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 4, 0, 4));
    instr("bne_t", 6'h05, 6'h00);
    cyc(1, 0, fe(1, 5));
    cyc(1, 0, de(5));
    cyc(1, 0, mk(10, 0, 0, 0, 0, 1, 1, 0, 0, 0, 1, 0, 0, 4, 0, 5));

    // JAL: link and jump in one state
    instr("jal", 6'h03, 6'h00);
    cyc(1, 0, fe(1, 6));
    cyc(1, 0, de(6));
    cyc(1, 0, mk(12, 0, 0, 0, 0, 1, 2, 1, 2, 0, 0, 0, 0, 7, 0, 6));

    // J: retirement wraps the 3-bit counter 7 -> 0
    instr("j", 6'h02, 6'h00);
    cyc(1, 0, fe(1, 7));
    cyc(1, 0, de(7));
    cyc(1, 0, mk(11, 0, 0, 0, 0, 1, 2, 0, 0, 0, 0, 0, 0, 1, 0, 7));

    // JR
    instr("jr", 6'h00, 6'h08);
    cyc(1, 0, fe(1, 0));
    cyc(1, 0, de(0));
    cyc(1, 0, mk(13, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 7, 0, 0));

    // Illegal opcode 3F, then MUL with HAS_MUL=0: both trap, retired unchanged
    instr("trap_3f", 6'h3F, 6'h00);
    cyc(1, 0, fe(1, 1));
    cyc(1, 0, de(1));
    cyc(1, 0, mk(14, 0, 0, 0, 0, 1, 3, 0, 0, 0, 0, 0, 0, 1, 1, 1));
    instr("trap_mul", 6'h1C, 6'h00);
    cyc(1, 0, fe(1, 1));
    cyc(1, 0, de(1));
    cyc(1, 0, mk(14, 0, 0, 0, 0, 1, 3, 0, 0, 0, 0, 0, 0, 1, 1, 1));

    // SW stalled in MEM_WR, then asynchronous reset mid-cycle
    instr("sw", 6'h2B, 6'h00);
    cyc(1, 0, fe(1, 1));
    cyc(1, 0, de(1));
    cyc(1, 0, mk(6, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 0, 1, 0, 1));
    cyc(0, 0, mk(9, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1));
    cyc(0, 0, mk(9, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1));
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst", got_now(), fe(0, 0));
    @(posedge clk);
    #1;
    chk("rst_held", got_now(), fe(0, 0));
    @(negedge clk);
    rst = 1'b0;

    // Recovery: ADD retires from a cleared counter
    instr("add_post_rst", 6'h00, 6'h20);
    cyc(1, 0, fe(1, 0));
    cyc(1, 0, de(0));
    cyc(1, 0, mk(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0));
    cyc(1, 0, mk(3, 0, 0, 0, 0, 0, 0, 1, 1, 0, 1, 0, 0, 1, 0, 0));
    cyc(0, 0, fe(0, 1));

    // Every queued expectation must have been consumed by the monitor
    @(negedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
